// File: rtl/iteration_controller_if.sv
// Job request and result handshake bundle for the iteration controller.
// slave  : the controller (accepts jobs, presents results).
// master : the job front-end / result consumer.
interface iteration_controller_if #(
    parameter int unsigned ID_W  = 8,
    parameter int unsigned CNT_W = 24
);
    logic             s_valid;
    logic             s_ready;
    logic [ID_W-1:0]  s_id;

    logic             m_valid;
    logic             m_ready;
    logic [ID_W-1:0]  m_id;
    logic [CNT_W-1:0] m_count;
    logic [1:0]       m_status;

    modport master (
        output s_valid, s_id, m_ready,
        input  s_ready, m_valid, m_id, m_count, m_status
    );

    modport slave (
        input  s_valid, s_id, m_ready,
        output s_ready, m_valid, m_id, m_count, m_status
    );
endinterface

// File: rtl/iteration_controller.sv
// Sequencer for the iterative datapath and its iteration counter.
// Accepts one job at a time, clears the counter for CLR_CYCLES cycles,
// enables iteration until abort / convergence / overflow, then presents
// the captured count and termination status. All outputs are registered.
module iteration_controller #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    iteration_controller_if.slave bus,
    input  logic                 abort,
    input  logic                 converged_in,
    input  logic [CNT_W-1:0]     cnt_in,
    input  logic                 ovf_in,
    output logic                 clr_out,
    output logic                 iter_en,
    output logic                 busy
);

    localparam int unsigned         TMR_W    = $clog2(CLR_CYCLES) + 1;
    localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(CLR_CYCLES - 1);

    localparam logic [1:0] ST_CONV  = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        REPORT
    } state_t;

    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic [ID_W-1:0]  job_id_q;
    logic             s_ready_q;
    logic             clr_q;
    logic             iter_q;
    logic             busy_q;
    logic             m_valid_q;
    logic [ID_W-1:0]  m_id_q;
    logic [CNT_W-1:0] m_count_q;
    logic [1:0]       m_status_q;

    // Sequencer FSM; each output register is updated together with the state
    // it belongs to. s_ready is held low during reset and rises on the first
    // edge after release.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            job_id_q   <= '0;
            s_ready_q  <= 1'b0;
            clr_q      <= 1'b1;
            iter_q     <= 1'b0;
            busy_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_id_q     <= '0;
            m_count_q  <= '0;
            m_status_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    if (bus.s_valid && s_ready_q) begin
                        job_id_q  <= bus.s_id;
                        tmr_q     <= TMR_LOAD;
                        s_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (tmr_q == '0) begin
                        clr_q   <= 1'b0;
                        iter_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                RUN: begin
                    if (abort || converged_in || ovf_in) begin
                        m_count_q <= cnt_in;
                        m_id_q    <= job_id_q;
                        if (abort) begin
                            m_status_q <= ST_ABORT;
                        end else if (converged_in) begin
                            m_status_q <= ST_CONV;
                        end else begin
                            m_status_q <= ST_OVF;
                        end
                        m_valid_q <= 1'b1;
                        iter_q    <= 1'b0;
                        clr_q     <= 1'b1;
                        state_q   <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_id     = m_id_q;
    assign bus.m_count  = m_count_q;
    assign bus.m_status = m_status_q;
    assign clr_out      = clr_q;
    assign iter_en      = iter_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_iteration_controller.sv
// Self-checking bench for iteration_controller. dut_a uses CLR_CYCLES = 2,
// dut_b uses CLR_CYCLES = 1 for the back-to-back scenario.
module tb_iteration_controller;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned ID_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    iteration_controller_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus_a ();
    iteration_controller_if #(.ID_W(ID_W), .CNT_W(CNT_W)) bus_b ();

    logic a_abort = 0, a_conv = 0, a_ovf = 0;
    logic [CNT_W-1:0] a_cnt = '0;
    logic a_clr, a_iter, a_busy;
    logic b_abort = 0, b_conv = 0, b_ovf = 0;
    logic [CNT_W-1:0] b_cnt = '0;
    logic b_clr, b_iter, b_busy;

    iteration_controller #(.CNT_W(CNT_W), .ID_W(ID_W), .CLR_CYCLES(2)) dut_a (
        .aclk(clk), .aresetn(rst), .bus(bus_a),
        .abort(a_abort), .converged_in(a_conv), .cnt_in(a_cnt), .ovf_in(a_ovf),
        .clr_out(a_clr), .iter_en(a_iter), .busy(a_busy)
    );

    iteration_controller #(.CNT_W(CNT_W), .ID_W(ID_W), .CLR_CYCLES(1)) dut_b (
        .aclk(clk), .aresetn(rst), .bus(bus_b),
        .abort(b_abort), .converged_in(b_conv), .cnt_in(b_cnt), .ovf_in(b_ovf),
        .clr_out(b_clr), .iter_en(b_iter), .busy(b_busy)
    );

    // Reference: termination status from the priority rule abort > converged > overflow.
    function automatic logic [1:0] ref_status(input bit ab, input bit cv, input bit ov);
        if (ab) return 2'b11;
        if (cv) return 2'b01;
        if (ov) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observations of the last job driven through dut_a.
    int               obs_clr, obs_iter, obs_vcyc;
    logic [ID_W-1:0]  obs_id;
    logic [CNT_W-1:0] obs_count;
    logic [1:0]       obs_status;
    bit               obs_unstable, obs_sready_bad, obs_timeout, obs_idle_after;

    // Drives one job into dut_a and records what it saw; terminating inputs
    // are applied on RUN cycle n_run, the result is back-pressured wait_n cycles.
    task automatic do_job(input logic [ID_W-1:0] id, input int n_run,
                          input bit ab, input bit cv, input bit ov,
                          input logic [CNT_W-1:0] cnt, input int wait_n,
                          input bit hold_next, input logic [ID_W-1:0] next_id);
        int t;
        obs_clr = 0; obs_iter = 0; obs_vcyc = 0;
        obs_unstable = 0; obs_sready_bad = 0; obs_timeout = 0; obs_idle_after = 0;
        bus_a.m_ready = (wait_n == 0);
        t = 0;
        while (!bus_a.s_ready && t < 30) begin step(); t++; end
        if (!bus_a.s_ready) obs_timeout = 1;
        bus_a.s_valid = 1'b1;
        bus_a.s_id    = id;
        step();
        bus_a.s_valid = 1'b0;
        bus_a.s_id    = ID_W'($urandom);
        t = 0;
        while (!a_iter && t < 30) begin
            if (a_clr && a_busy) obs_clr++;
            if (bus_a.s_ready) obs_sready_bad = 1;
            step(); t++;
        end
        if (!a_iter) obs_timeout = 1;
        if (hold_next) begin
            bus_a.s_valid = 1'b1;
            bus_a.s_id    = next_id;
        end
        t = 0;
        while (a_iter && t < n_run + 5) begin
            obs_iter++; t++;
            if (bus_a.s_ready) obs_sready_bad = 1;
            if (t == n_run) begin
                a_abort = ab; a_conv = cv; a_ovf = ov; a_cnt = cnt;
            end else begin
                a_abort = 0; a_conv = 0; a_ovf = 0; a_cnt = CNT_W'($urandom);
            end
            step();
        end
        a_abort = 0; a_conv = 0; a_ovf = 0; a_cnt = CNT_W'($urandom);
        if (a_iter) obs_timeout = 1;
        obs_id = bus_a.m_id; obs_count = bus_a.m_count; obs_status = bus_a.m_status;
        t = 0;
        while (bus_a.m_valid && t < wait_n + 5) begin
            obs_vcyc++;
            if (bus_a.m_id !== obs_id || bus_a.m_count !== obs_count ||
                bus_a.m_status !== obs_status) obs_unstable = 1;
            if (bus_a.s_ready) obs_sready_bad = 1;
            bus_a.m_ready = (t >= wait_n);
            t++;
            step();
        end
        if (bus_a.m_valid) obs_timeout = 1;
        obs_idle_after = !a_busy && bus_a.s_ready && !bus_a.m_valid && a_clr && !a_iter;
        bus_a.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus_a.s_ready); end
        checks++; if (a_clr !== 1'b1) begin errors++; $display("FAIL rst_clr: got %b want 1", a_clr); end
        checks++; if (a_iter !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_iter_busy: got %b%b want 00", a_iter, a_busy); end
        checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", bus_a.m_valid); end
        checks++; if (bus_a.m_id !== '0 || bus_a.m_count !== '0 || bus_a.m_status !== 2'b00) begin errors++; $display("FAIL rst_m_fields: got %h %h %b want 0 0 00", bus_a.m_id, bus_a.m_count, bus_a.m_status); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_s_ready: got %b want 0", bus_a.s_ready); end
        #3 rst = 1'b0;
        step();
        checks++; if (bus_a.s_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_release: s_ready=%b busy=%b want 1 0", bus_a.s_ready, a_busy); end
        // mid-stream reset in CLEAR
        bus_a.s_valid = 1'b1; bus_a.s_id = 8'h33;
        step();
        bus_a.s_valid = 1'b0;
        checks++; if (a_busy !== 1'b1 || bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL rst_accept: busy=%b s_ready=%b want 1 0", a_busy, bus_a.s_ready); end
        #3 rst = 1'b1;
        #1;
        checks++; if (a_busy !== 1'b0 || a_clr !== 1'b1 || bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: busy=%b clr=%b s_ready=%b want 0 1 0", a_busy, a_clr, bus_a.s_ready); end
        #3 rst = 1'b0;
        step();
        checks++; if (bus_a.s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release: got %b want 1", bus_a.s_ready); end
    endtask

    task automatic test_converge();
        do_job(8'h5A, 10, 0, 1, 0, 24'd9, 0, 0, 8'h00);
        checks++; if (obs_timeout) begin errors++; $display("FAIL conv_timeout: got 1 want 0"); end
        checks++; if (obs_clr !== 2) begin errors++; $display("FAIL conv_clr_cycles: got %0d want 2", obs_clr); end
        checks++; if (obs_iter !== 10) begin errors++; $display("FAIL conv_iter_cycles: got %0d want 10", obs_iter); end
        checks++; if (obs_id !== 8'h5A || obs_count !== 24'd9 || obs_status !== 2'b01) begin errors++; $display("FAIL conv_result: got %h %0d %b want 5a 9 01", obs_id, obs_count, obs_status); end
        checks++; if (obs_vcyc !== 1) begin errors++; $display("FAIL conv_valid_cycles: got %0d want 1", obs_vcyc); end
        checks++; if (!obs_idle_after || obs_sready_bad) begin errors++; $display("FAIL conv_idle: idle=%b sready_bad=%b want 1 0", obs_idle_after, obs_sready_bad); end
        checks++; if (bus_a.m_id !== 8'h5A || bus_a.m_count !== 24'd9) begin errors++; $display("FAIL conv_hold_in_idle: got %h %0d want 5a 9", bus_a.m_id, bus_a.m_count); end
    endtask

    task automatic test_overflow();
        logic [ID_W-1:0] id;
        id = ID_W'($urandom);
        do_job(id, 6, 0, 0, 1, 24'h3FF, 0, 0, 8'h00);
        checks++; if (obs_count !== 24'h3FF || obs_status !== 2'b10 || obs_id !== id) begin errors++; $display("FAIL ovf_result: got %h %h %b want %h 3ff 10", obs_id, obs_count, obs_status, id); end
        checks++; if (obs_iter !== 6 || obs_timeout) begin errors++; $display("FAIL ovf_iter_drop: got %0d to=%b want 6 0", obs_iter, obs_timeout); end
    endtask

    task automatic test_priority();
        do_job(8'h11, 3, 1, 1, 1, 24'd2, 0, 0, 8'h00);
        checks++; if (obs_status !== ref_status(1, 1, 1) || obs_count !== 24'd2) begin errors++; $display("FAIL prio_all: got %b %0d want %b 2", obs_status, obs_count, ref_status(1, 1, 1)); end
        do_job(8'h22, 2, 0, 1, 1, 24'd1, 0, 0, 8'h00);
        checks++; if (obs_status !== ref_status(0, 1, 1) || obs_id !== 8'h22) begin errors++; $display("FAIL prio_conv_ovf: got %b %h want %b 22", obs_status, obs_id, ref_status(0, 1, 1)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [ID_W-1:0] id;
            logic [CNT_W-1:0] cnt;
            bit ab, cv, ov;
            int n, w;
            id = ID_W'($urandom); cnt = CNT_W'($urandom);
            ab = 1'($urandom); cv = 1'($urandom); ov = 1'($urandom);
            if (!ab && !cv && !ov) ov = 1;
            n = int'($urandom_range(1, 12)); w = int'($urandom_range(0, 3));
            do_job(id, n, ab, cv, ov, cnt, w, 0, 8'h00);
            checks++; if (obs_id !== id || obs_count !== cnt || obs_status !== ref_status(ab, cv, ov)) begin errors++; $display("FAIL rnd_result[%0d]: got %h %h %b want %h %h %b", i, obs_id, obs_count, obs_status, id, cnt, ref_status(ab, cv, ov)); end
            checks++; if (obs_clr !== 2 || obs_iter !== n || obs_vcyc !== w + 1) begin errors++; $display("FAIL rnd_timing[%0d]: got clr=%0d iter=%0d v=%0d want 2 %0d %0d", i, obs_clr, obs_iter, obs_vcyc, n, w + 1); end
            checks++; if (obs_unstable || obs_sready_bad || obs_timeout || !obs_idle_after) begin errors++; $display("FAIL rnd_protocol[%0d]: got uns=%b srb=%b to=%b idle=%b want 0 0 0 1", i, obs_unstable, obs_sready_bad, obs_timeout, obs_idle_after); end
        end
    endtask

    task automatic test_backpressure();
        int t;
        do_job(8'hA1, 4, 0, 1, 0, 24'h123, 5, 1, 8'hB2);
        checks++; if (obs_vcyc !== 6 || obs_unstable) begin errors++; $display("FAIL bp_valid: got v=%0d uns=%b want 6 0", obs_vcyc, obs_unstable); end
        checks++; if (obs_id !== 8'hA1 || obs_count !== 24'h123 || obs_status !== 2'b01) begin errors++; $display("FAIL bp_result: got %h %h %b want a1 123 01", obs_id, obs_count, obs_status); end
        checks++; if (obs_sready_bad || !obs_idle_after) begin errors++; $display("FAIL bp_sready: got bad=%b idle=%b want 0 1", obs_sready_bad, obs_idle_after); end
        step();
        bus_a.s_valid = 1'b0;
        checks++; if (a_busy !== 1'b1 || bus_a.s_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_next: busy=%b s_ready=%b want 1 0", a_busy, bus_a.s_ready); end
        t = 0;
        while (!a_iter && t < 20) begin step(); t++; end
        a_conv = 1'b1; a_cnt = 24'd7; bus_a.m_ready = 1'b1;
        step();
        a_conv = 1'b0;
        checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_id !== 8'hB2) begin errors++; $display("FAIL bp_next_result: got v=%b id=%h want 1 b2", bus_a.m_valid, bus_a.m_id); end
        step();
        bus_a.m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int t;
        // mid-RUN
        bus_a.m_ready = 1'b0;
        t = 0;
        while (!bus_a.s_ready && t < 20) begin step(); t++; end
        bus_a.s_valid = 1'b1; bus_a.s_id = 8'h44;
        step();
        bus_a.s_valid = 1'b0;
        t = 0;
        while (!a_iter && t < 20) begin step(); t++; end
        step(); step();
        checks++; if (a_iter !== 1'b1) begin errors++; $display("FAIL ar_in_run: got iter=%b want 1", a_iter); end
        #3 rst = 1'b1;
        #1;
        checks++; if (a_iter !== 1'b0 || a_clr !== 1'b1 || bus_a.m_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL ar_run_now: iter=%b clr=%b mv=%b busy=%b want 0 1 0 0", a_iter, a_clr, bus_a.m_valid, a_busy); end
        #2 rst = 1'b0;
        step();
        checks++; if (bus_a.s_ready !== 1'b1) begin errors++; $display("FAIL ar_run_release: got %b want 1", bus_a.s_ready); end
        // mid-REPORT
        bus_a.s_valid = 1'b1; bus_a.s_id = 8'h55;
        step();
        bus_a.s_valid = 1'b0;
        t = 0;
        while (!a_iter && t < 20) begin step(); t++; end
        a_conv = 1'b1; a_cnt = 24'hABCDE;
        step();
        a_conv = 1'b0;
        step();
        checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_count !== 24'hABCDE) begin errors++; $display("FAIL ar_in_report: got v=%b cnt=%h want 1 abcde", bus_a.m_valid, bus_a.m_count); end
        #3 rst = 1'b1;
        #1;
        checks++; if (bus_a.m_valid !== 1'b0 || a_clr !== 1'b1 || a_iter !== 1'b0) begin errors++; $display("FAIL ar_report_now: mv=%b clr=%b iter=%b want 0 1 0", bus_a.m_valid, a_clr, a_iter); end
        checks++; if (bus_a.m_id !== '0 || bus_a.m_count !== '0 || bus_a.m_status !== 2'b00) begin errors++; $display("FAIL ar_report_fields: got %h %h %b want 0 0 00", bus_a.m_id, bus_a.m_count, bus_a.m_status); end
        #2 rst = 1'b0;
        step();
        checks++; if (bus_a.s_ready !== 1'b1 || bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL ar_report_release: s_ready=%b mv=%b want 1 0", bus_a.s_ready, bus_a.m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [ID_W-1:0] sent[$];
        logic [ID_W-1:0] got[$];
        int unsigned     acc[$];
        logic [ID_W-1:0] base;
        bit              accept;
        base = ID_W'($urandom);
        b_conv = 1'b1; b_cnt = 24'd1;
        bus_b.m_ready = 1'b1;
        bus_b.s_id    = base;
        bus_b.s_valid = 1'b1;
        for (int t = 0; t < 80; t++) begin
            if (bus_b.m_valid) got.push_back(bus_b.m_id);
            accept = bus_b.s_valid && bus_b.s_ready;
            if (accept) begin
                sent.push_back(bus_b.s_id);
                acc.push_back(cyc);
            end
            step();
            if (accept) begin
                if (sent.size() == 8) bus_b.s_valid = 1'b0;
                else bus_b.s_id = base + ID_W'(sent.size() * 37);
            end
            if (got.size() == 8) break;
        end
        bus_b.s_valid = 1'b0;
        checks++; if (sent.size() != 8 || got.size() != 8) begin errors++; $display("FAIL b2b_counts: got sent=%0d recv=%0d want 8 8", sent.size(), got.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < got.size() && i < sent.size()) begin
                checks++; if (got[i] !== base + ID_W'(i * 37)) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], base + ID_W'(i * 37)); end
            end
            if (i > 0 && i < acc.size()) begin
                checks++; if (acc[i] - acc[i-1] != 4) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, acc[i] - acc[i-1]); end
            end
        end
        b_conv = 1'b0;
    endtask

    initial begin
        bus_a.s_valid = 1'b0; bus_a.s_id = '0; bus_a.m_ready = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_id = '0; bus_b.m_ready = 1'b0;
        test_reset();
        test_converge();
        test_overflow();
        test_priority();
        test_random();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iteration_controller.md
Name: iteration_controller

Overview:
- Master-side sequencer for the iteration counter. It drives the counter's clear, gates the datapath iteration enable, and watches the counter value and overflow flag to end each job.
- Jobs arrive on a valid/ready request port. Results (final iteration count plus termination status) leave on a valid/ready result port.
- Sits between the accelerator's job front-end and the iterative datapath plus its iteration counter.

Parameters:
- CNT_W, 24, width of counter value input and result count.
- ID_W, 8, width of job tag.
- CLR_CYCLES, 2, number of cycles clr_out is held high before a run. Minimum 1. Default 2 flushes the counter's one-cycle output register.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-high (asserted = 1).
- s_valid  in  1  job request valid.
- s_ready  out  1  controller can accept a job.
- s_id  in  ID_W  job tag, captured on acceptance.
- abort  in  1  terminate the current run.
- converged_in  in  1  datapath reports convergence this cycle.
- cnt_in  in  CNT_W  iteration counter value.
- ovf_in  in  1  iteration counter saturated.
- clr_out  out  1  clear to the iteration counter.
- iter_en  out  1  datapath iteration enable.
- busy  out  1  high whenever state is not IDLE.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_id  out  ID_W  tag of the finished job.
- m_count  out  CNT_W  cnt_in captured at termination.
- m_status  out  2  01 = converged, 10 = overflow, 11 = aborted, 00 never presented.

Behaviour:
- Reset (aresetn = 1, asynchronous): state = IDLE immediately, not at the next edge.
  - Outputs during and after reset: s_ready = 0 while reset is asserted, then 1 from the first cycle after release. clr_out = 1, iter_en = 0, busy = 0, m_valid = 0, m_id = 0, m_count = 0, m_status = 00.
- States: IDLE, CLEAR, RUN, REPORT. All outputs are decoded from registered state or registers only, with no combinational input-to-output paths.
- IDLE:
  - s_ready = 1, clr_out = 1, iter_en = 0.
  - On s_valid && s_ready at edge k: capture s_id, go to CLEAR. Load the clear timer with CLR_CYCLES-1.
- CLEAR:
  - s_ready = 0, clr_out = 1, iter_en = 0.
  - Lasts exactly CLR_CYCLES cycles (k+1 .. k+CLR_CYCLES), then RUN.
  - abort is ignored in CLEAR.
- RUN (from cycle k+CLR_CYCLES+1):
  - clr_out = 0, iter_en = 1.
  - Each cycle evaluates the terminating conditions in priority order: abort > converged_in > ovf_in.
  - On any condition: register m_count <= cnt_in and m_status per the priority winner, go to REPORT. iter_en drops the next cycle.
  - Simultaneous converged_in and ovf_in: status 01. abort together with either: status 11.
  - With no condition, RUN continues indefinitely; the counter saturates and ovf_in ends the run.
- REPORT:
  - m_valid = 1, clr_out = 1, iter_en = 0, s_ready = 0.
  - m_id, m_count, m_status are held stable until m_valid && m_ready.
  - Transfer occurs on the first REPORT cycle if m_ready is already high. The next state is IDLE in either case.
  - m_valid deasserts the cycle after transfer. m_id, m_count, m_status keep their last values in IDLE.
- Backpressure: a job presented while not IDLE sees s_ready = 0 and must be held by the sender. There is no queueing; one job is in flight at most.
- Minimum job-to-job spacing: CLR_CYCLES + 3 cycles (accept, CLEAR, ≥1 RUN, REPORT).
- Inputs converged_in, ovf_in and cnt_in are sampled only in RUN. Their values in other states are don't-care.
- Reset mid-operation from any state: asynchronous return to IDLE with reset values. Any pending result is discarded (m_valid = 0).
- Arithmetic: the only counter is the CLEAR timer, width clog2(CLR_CYCLES)+1. It has no wrap; it is reloaded on every acceptance.

Test Plan:
- Reset, basic convergence: reset mid-stream, release. Send s_id = 0x5A. Assert converged_in on the 10th RUN cycle with cnt_in = 9, m_ready = 1. Expect clr_out high for 2 cycles, then iter_en high for 10 cycles, then m_valid one cycle with m_id = 0x5A, m_count = 9, m_status = 01; IDLE next.
- Overflow termination: job, no convergence, drive ovf_in = 1 with cnt_in = 0x3FF. Expect m_count = 0x3FF, m_status = 10, iter_en low the following cycle.
- Priority: same cycle assert abort, converged_in, ovf_in. Expect m_status = 11. Repeat with converged_in and ovf_in only: expect m_status = 01.
- Result backpressure: m_ready = 0 for 5 REPORT cycles while a new s_valid is held. Expect m_valid with stable fields, s_ready = 0 throughout, the new job accepted only in IDLE after transfer.
- Async reset mid-RUN and mid-REPORT: assert aresetn between clock edges. Expect m_valid = 0, iter_en = 0, clr_out = 1 immediately, before the next edge. Expect s_ready = 1 on the first cycle after release.
- Back-to-back jobs with s_valid held high and CLR_CYCLES = 1, converging on the first RUN cycle: expect acceptance every 4 cycles, with distinct m_id values delivered in order.
